// File: rtl/video_timing_gen_v2.sv
// video_timing_gen_v2: parametrised raster timing generator (progressive or interlaced).
// Generates hsync, vsync, de and a read-ahead strobe rd from h/v counters. Configuration is
// captured into a shadow set and committed to the active set only when idle or at frame end,
// after a legality check.
// Optional feature: define VTG_FRAME_CNT_EN to add the 16-bit o_frm_cnt frame counter port.
module video_timing_gen_v2 #(
   parameter int unsigned CNT_W   = 13,
   parameter int unsigned RD_LEAD = 1,
   parameter bit          HS_POL  = 1'b1,
   parameter bit          VS_POL  = 1'b1
) (
   input  logic             i_video_clk,
   input  logic             i_rst_n,
   input  logic             i_enable,
   input  logic             i_cfg_load,
   input  logic             i_cfg_interlace,
   input  logic [CNT_W-1:0] i_hs_total,
   input  logic [CNT_W-1:0] i_vs_total,
   input  logic [CNT_W-1:0] i_hsyn_num,
   input  logic [CNT_W-1:0] i_vsyn_num,
   input  logic [CNT_W-1:0] i_start_pixel,
   input  logic [CNT_W-1:0] i_end_pixel,
   input  logic [CNT_W-1:0] i_start_H,
   input  logic [CNT_W-1:0] i_end_H,
   output logic             o_hsyn,
   output logic             o_vsyn,
   output logic             o_de,
   output logic             o_rd,
   output logic             o_field,
   output logic             o_sof,
   output logic             o_busy,
   output logic             o_cfg_ack,
   output logic             o_cfg_err
`ifdef VTG_FRAME_CNT_EN
   ,
   output logic [15:0]      o_frm_cnt
`endif
);

   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CntTwo  = CNT_W'(2);
   localparam logic [CNT_W-1:0] CntFour = CNT_W'(4);
   localparam logic [CNT_W-1:0] RdLead  = CNT_W'(RD_LEAD);

   typedef struct packed {
      logic             il;
      logic [CNT_W-1:0] h_tot;
      logic [CNT_W-1:0] v_tot;
      logic [CNT_W-1:0] hsyn;
      logic [CNT_W-1:0] vsyn;
      logic [CNT_W-1:0] sp;
      logic [CNT_W-1:0] ep;
      logic [CNT_W-1:0] sh;
      logic [CNT_W-1:0] eh;
   } cfg_t;

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   // Lines per field: V when progressive, ceil(V/2) when interlaced (overflow-free form).
   function automatic logic [CNT_W-1:0] field_lines(input cfg_t c);
      return c.il ? ((c.v_tot >> 1) + {{(CNT_W-1){1'b0}}, c.v_tot[0]}) : c.v_tot;
   endfunction

   function automatic logic cfg_legal(input cfg_t c);
      logic [CNT_W-1:0] fl;
      fl = field_lines(c);
      return (c.h_tot >= CntFour) &&
             (c.v_tot >= (c.il ? CntFour : CntTwo)) &&
             (c.hsyn != '0) && (c.hsyn < c.h_tot) &&
             (c.vsyn != '0) && (c.vsyn < fl) &&
             (c.sp >= RdLead) && (c.sp < c.ep) && (c.ep <= c.h_tot) &&
             (c.sh < c.eh) && (c.eh <= fl);
   endfunction

   cfg_t             cfg_in, shadow_q, act_q;
   logic             pend_q, pend_d, valid_q, valid_d;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
   logic             h_last, v_last, frame_end, commit, legal, run;
   logic [CNT_W-1:0] fb, half, line_v;
   logic             in_field1, line_on, hs_d, vs_d, de_d, rd_d;
   logic             hs_q, vs_q, de_q, rd_q, field_q, sof_q, ack_q, err_q;

   assign cfg_in = '{il: i_cfg_interlace, h_tot: i_hs_total, v_tot: i_vs_total,
                     hsyn: i_hsyn_num, vsyn: i_vsyn_num, sp: i_start_pixel,
                     ep: i_end_pixel, sh: i_start_H, eh: i_end_H};

   assign run       = (state_q == StRun);
   assign h_last    = (h_q == act_q.h_tot - CntOne);
   assign v_last    = (v_q == act_q.v_tot - CntOne);
   assign frame_end = run && h_last && v_last;
   // A pending shadow commits immediately while idle, otherwise only on the last frame clock.
   assign commit    = pend_q && (!run || frame_end);
   assign legal     = cfg_legal(shadow_q);
   assign valid_d   = commit ? legal : valid_q;
   // A load on the commit clock keeps the new data pending for the next boundary.
   assign pend_d    = i_cfg_load | (pend_q & ~commit);

   // Shadow capture, commit into the active set, and the valid flag.
   always_ff @(posedge i_video_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         shadow_q <= '0;
         act_q    <= '0;
         pend_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         valid_q <= valid_d;
         if (i_cfg_load) begin
            shadow_q <= cfg_in;
         end
         if (commit) begin
            act_q <= legal ? shadow_q : '0;
         end
      end
   end

   // Run/idle control and raster counter next state.
   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      v_d     = v_q;
      unique case (state_q)
         StIdle: begin
            h_d = '0;
            v_d = '0;
            if (i_enable && valid_q) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (frame_end) begin
               h_d = '0;
               v_d = '0;
               // valid_d: an illegal commit at this boundary also stops the raster.
               if (!(i_enable && valid_d)) begin
                  state_d = StIdle;
               end
            end else if (h_last) begin
               h_d = '0;
               v_d = v_q + CntOne;
            end else begin
               h_d = h_q + CntOne;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and counter registers.
   always_ff @(posedge i_video_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         h_q     <= '0;
         v_q     <= '0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         v_q     <= v_d;
      end
   end

   // Decode sync/de/rd windows for the current counter position.
   always_comb begin
      fb        = field_lines(act_q);
      half      = act_q.h_tot >> 1;
      in_field1 = act_q.il && (v_q >= fb);
      line_v    = in_field1 ? (v_q - fb) : v_q;
      line_on   = (line_v >= act_q.sh) && (line_v < act_q.eh);
      hs_d      = (h_q < act_q.hsyn);
      vs_d      = (v_q < act_q.vsyn);
      if (in_field1) begin
         // Field1 vsync spans half a line later: (fb, H/2) up to (fb+vsyn, H/2).
         vs_d = ((v_q > fb) || (h_q >= half)) &&
                ((v_q < fb + act_q.vsyn) || ((v_q == fb + act_q.vsyn) && (h_q < half)));
      end
      de_d = line_on && (h_q >= act_q.sp) && (h_q < act_q.ep);
      rd_d = line_on && (h_q >= act_q.sp - RdLead) && (h_q < act_q.ep - RdLead);
   end

   // Registered outputs; everything inactive while idle.
   always_ff @(posedge i_video_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hs_q    <= 1'b0;
         vs_q    <= 1'b0;
         de_q    <= 1'b0;
         rd_q    <= 1'b0;
         field_q <= 1'b0;
         sof_q   <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         hs_q    <= run && hs_d;
         vs_q    <= run && vs_d;
         de_q    <= run && de_d;
         rd_q    <= run && rd_d;
         field_q <= run && in_field1;
         sof_q   <= run && (h_q == '0) && (v_q == '0);
         ack_q   <= commit && legal;
         err_q   <= commit && !legal;
      end
   end

   assign o_hsyn    = HS_POL ? hs_q : ~hs_q;
   assign o_vsyn    = VS_POL ? vs_q : ~vs_q;
   assign o_de      = de_q;
   assign o_rd      = rd_q;
   assign o_field   = field_q;
   assign o_sof     = sof_q;
   assign o_busy    = run;
   assign o_cfg_ack = ack_q;
   assign o_cfg_err = err_q;

`ifdef VTG_FRAME_CNT_EN
   logic [15:0] frm_cnt_q;

   // Frame counter: steps on each sof pulse, cleared by a legal commit while idle.
   always_ff @(posedge i_video_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         frm_cnt_q <= '0;
      end else if (commit && legal && !run) begin
         frm_cnt_q <= '0;
      end else if (sof_q) begin
         frm_cnt_q <= frm_cnt_q + 16'd1;
      end
   end

   assign o_frm_cnt = frm_cnt_q;
`endif

endmodule

// File: tb/tb_video_timing_gen_v2.sv
// Bench for video_timing_gen_v2: a pixel-index based reference model checked every cycle,
// plus directed scenarios with hand-computed event counts and latencies.
module tb_video_timing_gen_v2;

   localparam int CW = 13;
   localparam int RD = 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          cfg_load = 1'b0;
   logic          cfg_il = 1'b0;
   logic [CW-1:0] hs_total = '0, vs_total = '0, hsyn_num = '0, vsyn_num = '0;
   logic [CW-1:0] start_pixel = '0, end_pixel = '0, start_h = '0, end_h = '0;
   logic          o_hsyn, o_vsyn, o_de, o_rd, o_field, o_sof, o_busy, o_cfg_ack, o_cfg_err;

   int n_vec = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   video_timing_gen_v2 #(
      .CNT_W   (CW),
      .RD_LEAD (RD),
      .HS_POL  (1'b1),
      .VS_POL  (1'b1)
   ) dut (
      .i_video_clk     (clk),
      .i_rst_n         (rst_n),
      .i_enable        (enable),
      .i_cfg_load      (cfg_load),
      .i_cfg_interlace (cfg_il),
      .i_hs_total      (hs_total),
      .i_vs_total      (vs_total),
      .i_hsyn_num      (hsyn_num),
      .i_vsyn_num      (vsyn_num),
      .i_start_pixel   (start_pixel),
      .i_end_pixel     (end_pixel),
      .i_start_H       (start_h),
      .i_end_H         (end_h),
      .o_hsyn          (o_hsyn),
      .o_vsyn          (o_vsyn),
      .o_de            (o_de),
      .o_rd            (o_rd),
      .o_field         (o_field),
      .o_sof           (o_sof),
      .o_busy          (o_busy),
      .o_cfg_ack       (o_cfg_ack),
      .o_cfg_err       (o_cfg_err)
   );

   // ---------------- reference model ----------------
   typedef struct {
      int il, h, v, hs, vs, sp, ep, sh, eh;
   } cfg_s;

   cfg_s       m_act = '{default: 0};
   cfg_s       m_shd = '{default: 0};
   bit         m_valid = 1'b0, m_pend = 1'b0, m_run = 1'b0;
   int         m_pos = 0;
   logic [8:0] m_exp = '0;

   function automatic bit legal(input cfg_s c);
      int fl;
      fl = c.il ? (c.v + 1) / 2 : c.v;
      return c.h >= 4 && c.v >= (c.il ? 4 : 2) && c.hs > 0 && c.hs < c.h &&
             c.vs > 0 && c.vs < fl && RD <= c.sp && c.sp < c.ep && c.ep <= c.h &&
             c.sh < c.eh && c.eh <= fl;
   endfunction

   // {hs, vs, de, rd, field} for linear pixel index p of a frame.
   function automatic logic [4:0] pix(input cfg_s c, input int p);
      int h, v, fb, lv;
      bit fld, line, hs, vs, de, rd;
      h    = p % c.h;
      v    = p / c.h;
      fb   = c.il ? (c.v + 1) / 2 : c.v;
      fld  = (c.il != 0) && v >= fb;
      lv   = fld ? v - fb : v;
      line = lv >= c.sh && lv < c.eh;
      hs   = h < c.hs;
      if (c.il == 0) vs = v < c.vs;
      else vs = (p < c.vs * c.h) ||
                (p >= fb * c.h + c.h / 2 && p < (fb + c.vs) * c.h + c.h / 2);
      de = line && h >= c.sp && h < c.ep;
      rd = line && h + RD >= c.sp && h + RD < c.ep;
      return {hs, vs, de, rd, fld};
   endfunction

   // Advance the model by one clock using the inputs present at that clock.
   task automatic step();
      logic [4:0] px;
      bit sof, last, commit, ack, err, was_valid;
      px        = m_run ? pix(m_act, m_pos) : 5'b0;
      sof       = m_run && m_pos == 0;
      last      = m_run && m_pos == m_act.h * m_act.v - 1;
      commit    = m_pend && (!m_run || last);
      was_valid = m_valid;
      ack       = 1'b0;
      err       = 1'b0;
      if (commit) begin
         if (legal(m_shd)) begin
            m_act   = m_shd;
            m_valid = 1'b1;
            ack     = 1'b1;
         end else begin
            m_valid = 1'b0;
            err     = 1'b1;
         end
         m_pend = 1'b0;
      end
      if (cfg_load) begin
         m_shd  = '{int'(cfg_il), int'(hs_total), int'(vs_total), int'(hsyn_num),
                    int'(vsyn_num), int'(start_pixel), int'(end_pixel), int'(start_h),
                    int'(end_h)};
         m_pend = 1'b1;
      end
      if (!m_run) begin
         if (enable && was_valid) begin
            m_run = 1'b1;
            m_pos = 0;
         end
      end else if (last) begin
         m_pos = 0;
         if (!(enable && m_valid)) m_run = 1'b0;
      end else begin
         m_pos++;
      end
      m_exp = {px, sof, m_run, ack, err};
   endtask

   function automatic logic [8:0] dut_vec();
      return {o_hsyn, o_vsyn, o_de, o_rd, o_field, o_sof, o_busy, o_cfg_ack, o_cfg_err};
   endfunction

   // Inputs change only at negedge+1, so at a negedge they still equal the last posedge's.
   initial begin : compare
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_act = '{default: 0};
            m_shd = '{default: 0};
            m_valid = 1'b0;
            m_pend  = 1'b0;
            m_run   = 1'b0;
            m_pos   = 0;
            m_exp   = '0;
         end else begin
            step();
         end
         if (cmp_en) begin
            n_vec++;
            if (dut_vec() !== m_exp) begin
               n_err++;
               $display("FAIL cycle_outputs @%0t: got %b, expected %b (hs vs de rd fld sof busy ack err)",
                        $time, dut_vec(), m_exp);
            end
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic load_cfg(input int il, input int h, input int v, input int hs, input int vs,
                           input int sp, input int ep, input int sh, input int eh);
      @(negedge clk);
      #1;
      cfg_il      = il[0];
      hs_total    = CW'(h);
      vs_total    = CW'(v);
      hsyn_num    = CW'(hs);
      vsyn_num    = CW'(vs);
      start_pixel = CW'(sp);
      end_pixel   = CW'(ep);
      start_h     = CW'(sh);
      end_h       = CW'(eh);
      cfg_load    = 1'b1;
      @(negedge clk);
      #1 cfg_load = 1'b0;
   endtask

   function automatic bit sig(input int sel);
      case (sel)
         0:       return o_sof === 1'b1;
         1:       return o_cfg_ack === 1'b1;
         2:       return o_cfg_err === 1'b1;
         default: return o_busy === 1'b0;
      endcase
   endfunction

   // Counts negedges until the selected event is seen; -1 when the bound expires.
   task automatic wait_for(input int sel, input int max, output int cnt);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!sig(sel) && cnt < max);
      if (!sig(sel)) cnt = -1;
   endtask

   int c_de, c_rd, c_hs, c_vs, c_sof, c_field, c_busy, first_de, first_rd, vs_rise, vs_fall;

   // Samples n consecutive cycles starting at the current one.
   task automatic measure(input int n);
      logic prev_vs;
      prev_vs = 1'b0;
      {c_de, c_rd, c_hs, c_vs, c_sof, c_field, c_busy} = '0;
      first_de = -1;
      first_rd = -1;
      vs_rise  = -1;
      vs_fall  = -1;
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk);
         if (o_de)    c_de++;
         if (o_rd)    c_rd++;
         if (o_hsyn)  c_hs++;
         if (o_vsyn)  c_vs++;
         if (o_sof)   c_sof++;
         if (o_field) c_field++;
         if (o_busy)  c_busy++;
         if (o_de && first_de < 0) first_de = i;
         if (o_rd && first_rd < 0) first_rd = i;
         if (i > 0 && o_vsyn && !prev_vs && vs_rise < 0) vs_rise = i;
         if (vs_rise >= 0 && !o_vsyn && prev_vs && vs_fall < 0) vs_fall = i;
         prev_vs = o_vsyn;
      end
   endtask

   // ---------------- scenarios ----------------
   initial begin : stim
      int cnt;
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'(dut_vec()), 0);
      cmp_en = 1'b1;
      #1 rst_n = 1'b1;

      // Progressive 10x6 raster.
      load_cfg(0, 10, 6, 2, 1, 3, 8, 2, 5);
      enable = 1'b1;
      wait_for(0, 500, cnt);
      check("t1_start_latency", cnt, 3);
      measure(60);
      check("t1_de_count", c_de, 15);
      check("t1_rd_count", c_rd, 15);
      check("t1_hs_count", c_hs, 12);
      check("t1_vs_count", c_vs, 10);
      check("t1_sof_count", c_sof, 1);
      check("t1_first_de", first_de, 23);
      check("t1_first_rd", first_rd, 22);
      @(negedge clk);
      check("t1_sof_period", 32'(o_sof), 1);

      // Mid-frame reload with H=12: commit only at frame end.
      repeat (20) @(negedge clk);
      load_cfg(0, 12, 6, 2, 1, 3, 8, 2, 5);
      wait_for(1, 500, cnt);
      check("t2_ack_at_frame_end", cnt, 37);
      wait_for(0, 500, cnt);
      check("t2_sof_after_ack", cnt, 1);
      wait_for(0, 500, cnt);
      check("t2_new_frame_len", cnt, 72);

      // Stop request at v=2: frame completes, then idle.
      repeat (24) @(negedge clk);
      #1 enable = 1'b0;
      wait_for(3, 500, cnt);
      check("t5_busy_drop", cnt, 47);
      @(negedge clk);
      check("t5_idle_outputs", 32'(dut_vec()), 0);

      // Illegal config while idle: err pulse, valid dropped.
      load_cfg(0, 10, 6, 2, 1, 3, 11, 2, 5);
      wait_for(2, 50, cnt);
      check("t3_err_delay", cnt, 1);
      #1 enable = 1'b1;
      measure(20);
      check("t3_no_busy", c_busy, 0);

      // Interlaced 10x11.
      load_cfg(1, 10, 11, 2, 1, 3, 8, 1, 4);
      wait_for(0, 500, cnt);
      check("t4_start_latency", cnt, 3);
      measure(110);
      check("t4_vs_count", c_vs, 20);
      check("t4_field_count", c_field, 50);
      check("t4_de_count", c_de, 30);
      check("t4_rd_count", c_rd, 30);
      check("t4_hs_count", c_hs, 22);
      check("t4_f1_vs_rise", vs_rise, 65);
      check("t4_f1_vs_fall", vs_fall, 75);
      @(negedge clk);
      check("t4_seamless_sof", 32'(o_sof), 1);

      // Asynchronous reset in the middle of an active line.
      repeat (24) @(negedge clk);
      check("t6_de_before_reset", 32'(o_de), 1);
      #1 rst_n = 1'b0;
      #1;
      check("t6_async_clear", 32'(dut_vec()), 0);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      measure(20);
      check("t6_no_busy_after_reset", c_busy, 0);
      load_cfg(0, 10, 6, 2, 1, 3, 8, 2, 5);
      wait_for(0, 500, cnt);
      check("t6_restart_latency", cnt, 3);
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
